// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier with status output.
// Classification treats denormals as zero.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_t;

  localparam int ZERO    = 0;
  localparam int INF     = 1;
  localparam int NAN     = 2;
  localparam int TINY    = 3;
  localparam int HUGE    = 4;
  localparam int INEXACT = 5;

  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam logic [31:0] MAX_NORMAL = 32'h7F7F_FFFF;
  localparam logic [31:0] MIN_NORMAL = 32'h0080_0000;
  localparam int          BIAS       = 127;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    round_t      rnd;
  } op_t;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic [47:0]        prod;
    fp_class_t          ca;
    fp_class_t          cb;
    round_t             rnd;
  } stage1_t;

  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    c.zero = (x[30:23] == 8'h00);
    c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a normalized 23-bit mantissa given guard/sticky, sign and mode.
// Reports the carry out of the mantissa and whether bits were discarded.
module fp_round
  import fp_mul_pkg::*;
(
  input  logic        clk_unused_n,
  input  logic [22:0] mant,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  input  round_t      rnd,
  output logic [22:0] mant_out,
  output logic        carry,
  output logic        inexact
);

  logic inc;

  // NOTE: combinational logic uses blocking assignments, and every output gets a default first so no latch is inferred.
  always_comb begin
    inexact = guard | sticky;
    inc     = 1'b0;
    case (rnd)
      IEEE_near: inc = guard & (sticky | mant[0]);
      IEEE_zero: inc = 1'b0;
      IEEE_pinf: inc = inexact & ~sign;
      IEEE_ninf: inc = inexact & sign;
      near_up:   inc = guard;
      away_zero: inc = inexact;
      default:   inc = 1'b0;
    endcase
    {carry, mant_out} = {1'b0, mant} + 24'(inc);
  end

  logic unused;
  assign unused = clk_unused_n;

endmodule

// File: rtl/fp_mul_status_pipe.sv
// Pipelined FP32 multiplier: input capture, exponent/product stage, then
// normalize/round/special-case stage registering z and status together.
module fp_mul_status_pipe
  import fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  round_t      rnd,
  output logic        out_valid,
  output logic [31:0] z,
  output logic [7:0]  status
);

  op_t     op_q;
  logic    op_valid;
  stage1_t s1_d, s1_q;
  logic    s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      op_valid <= in_valid;
      s1_valid <= op_valid;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) op_q <= '{a: a, b: b, rnd: rnd};
    if (op_valid && !rst) s1_q <= s1_d;
  end

  always_comb begin
    s1_d.sign = op_q.a[31] ^ op_q.b[31];
    s1_d.exp  = {2'b00, op_q.a[30:23]} + {2'b00, op_q.b[30:23]} - 10'(BIAS);
    s1_d.prod = 48'({1'b1, op_q.a[22:0]}) * 48'({1'b1, op_q.b[22:0]});
    s1_d.ca   = classify(op_q.a);
    s1_d.cb   = classify(op_q.b);
    s1_d.rnd  = op_q.rnd;
  end

  logic [22:0]       mant_n, mant_r;
  logic              guard, sticky, carry, inexact;
  logic signed [9:0] exp_n, exp_r;

  always_comb begin
    if (s1_q.prod[47]) begin
      mant_n = s1_q.prod[46:24];
      guard  = s1_q.prod[23];
      sticky = |s1_q.prod[22:0];
    end else begin
      mant_n = s1_q.prod[45:23];
      guard  = s1_q.prod[22];
      sticky = |s1_q.prod[21:0];
    end
    exp_n = s1_q.exp + $signed({9'd0, s1_q.prod[47]});
  end

  fp_round u_round (
    .clk_unused_n (clk),
    .mant         (mant_n),
    .guard        (guard),
    .sticky       (sticky),
    .sign         (s1_q.sign),
    .rnd          (s1_q.rnd),
    .mant_out     (mant_r),
    .carry        (carry),
    .inexact      (inexact)
  );

  logic [31:0] z_d;
  logic [7:0]  status_d;
  logic        toward_sign;
  logic        any_nan, any_inf, any_zero;

  always_comb begin
    z_d         = '0;
    status_d    = '0;
    exp_r       = exp_n + $signed({9'd0, carry});
    toward_sign = (s1_q.rnd == IEEE_pinf && !s1_q.sign) ||
                  (s1_q.rnd == IEEE_ninf &&  s1_q.sign);
    any_nan     = s1_q.ca.nan | s1_q.cb.nan |
                  (s1_q.ca.zero & s1_q.cb.inf) | (s1_q.ca.inf & s1_q.cb.zero);
    any_inf     = s1_q.ca.inf | s1_q.cb.inf;
    any_zero    = s1_q.ca.zero | s1_q.cb.zero;

    if (any_nan) begin
      z_d           = QNAN;
      status_d[NAN] = 1'b1;
    end else if (any_inf) begin
      z_d           = {s1_q.sign, 8'hFF, 23'd0};
      status_d[INF] = 1'b1;
    end else if (any_zero) begin
      z_d            = {s1_q.sign, 31'd0};
      status_d[ZERO] = 1'b1;
    end else if (exp_r >= 10'sd255) begin
      status_d[HUGE]    = 1'b1;
      status_d[INEXACT] = 1'b1;
      if (s1_q.rnd inside {IEEE_near, near_up, away_zero} || toward_sign) begin
        z_d           = {s1_q.sign, 8'hFF, 23'd0};
        status_d[INF] = 1'b1;
      end else begin
        z_d = {s1_q.sign, MAX_NORMAL[30:0]};
      end
    end else if (exp_r <= 10'sd0) begin
      // Results below minNormal are never emitted as denormals.
      status_d[TINY]    = 1'b1;
      status_d[INEXACT] = 1'b1;
      if (s1_q.rnd == away_zero || toward_sign) begin
        z_d = {s1_q.sign, MIN_NORMAL[30:0]};
      end else begin
        z_d            = {s1_q.sign, 31'd0};
        status_d[ZERO] = 1'b1;
      end
    end else begin
      z_d               = {s1_q.sign, exp_r[7:0], mant_r};
      status_d[INEXACT] = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      status    <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z      <= z_d;
        status <= status_d;
      end
    end
  end

endmodule
